// File: rtl/wb_tlul_bridge.sv
// Single-outstanding Caravel Wishbone slave to TL-UL host bridge.
// Optional D-channel timeout: define WB_TLUL_TIMEOUT_EN.
module wb_tlul_bridge #(
    parameter int SRC_ID         = 0,
    parameter int SRC_W          = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             tl_a_valid_o,
    input  logic             tl_a_ready_i,
    output logic [2:0]       tl_a_opcode_o,
    output logic [1:0]       tl_a_size_o,
    output logic [3:0]       tl_a_mask_o,
    output logic [31:0]      tl_a_address_o,
    output logic [31:0]      tl_a_data_o,
    output logic [SRC_W-1:0] tl_a_source_o,
    input  logic             tl_d_valid_i,
    output logic             tl_d_ready_o,
    input  logic [2:0]       tl_d_opcode_i,
    input  logic [31:0]      tl_d_data_i,
    input  logic             tl_d_error_i,
    input  logic [SRC_W-1:0] tl_d_source_i
);

    // state  | meaning
    // IDLE   | waiting for stb&cyc; stray D beats accepted and dropped
    // A_REQ  | A channel valid, waiting for a_ready
    // D_WAIT | waiting for the D response (or timeout)
    // ACK    | one-cycle Wishbone ack (suppressed if cyc was dropped)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_REQ  = 2'd1,
        D_WAIT = 2'd2,
        ACK    = 2'd3
    } state_e;

    localparam logic [2:0]  OP_PUT_FULL    = 3'd0;
    localparam logic [2:0]  OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0]  OP_GET         = 3'd4;
    localparam logic [31:0] ERR_DATA       = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        a_valid_q, a_valid_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;

`ifdef WB_TLUL_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_hit;
    assign tmo_hit = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        a_valid_d = a_valid_q;
        d_ready_d = d_ready_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
`ifdef WB_TLUL_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    we_d      = wbs_we_i;
                    sel_d     = wbs_sel_i;
                    adr_d     = {wbs_adr_i[31:2], 2'b00};
                    wdata_d   = wbs_dat_i;
                    a_valid_d = 1'b1;
                    d_ready_d = 1'b0;
                    state_d   = A_REQ;
                end
            end
            A_REQ: begin
                if (tl_a_ready_i) begin
                    a_valid_d = 1'b0;
                    d_ready_d = 1'b1;
                    state_d   = D_WAIT;
`ifdef WB_TLUL_TIMEOUT_EN
                    cnt_d     = 16'd0;
`endif
                end
            end
            D_WAIT: begin
                if (tl_d_valid_i && d_ready_q) begin
                    if (tl_d_error_i) begin
                        rdata_d = ERR_DATA;
                    end else if (!we_q) begin
                        rdata_d = tl_d_data_i;
                    end
                    d_ready_d = 1'b0;
                    ack_d     = wbs_cyc_i;
                    state_d   = ACK;
                end
`ifdef WB_TLUL_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 16'd1;
                    if (tmo_hit) begin
                        rdata_d   = ERR_DATA;
                        d_ready_d = 1'b0;
                        ack_d     = wbs_cyc_i;
                        state_d   = ACK;
                    end
                end
`endif
            end
            ACK: begin
                d_ready_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                a_valid_d = 1'b0;
                d_ready_d = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            rdata_q   <= 32'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            adr_q     <= 32'd0;
            wdata_q   <= 32'd0;
`ifdef WB_TLUL_TIMEOUT_EN
            cnt_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            a_valid_q <= a_valid_d;
            d_ready_q <= d_ready_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
`ifdef WB_TLUL_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // A payload comes straight from the request registers, so it is stable while valid.
    assign tl_a_opcode_o  = !we_q ? OP_GET :
                            (sel_q == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
    assign tl_a_size_o    = 2'd2;
    assign tl_a_mask_o    = sel_q;
    assign tl_a_address_o = adr_q;
    assign tl_a_data_o    = wdata_q;
    assign tl_a_source_o  = SRC_W'(SRC_ID);
    assign tl_a_valid_o   = a_valid_q;
    assign tl_d_ready_o   = d_ready_q;
    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = rdata_q;

    logic unused_ok;
`ifdef WB_TLUL_TIMEOUT_EN
    assign unused_ok = ^{tl_d_opcode_i, tl_d_source_i};
`else
    assign unused_ok = ^{tl_d_opcode_i, tl_d_source_i, 16'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_wb_tlul_bridge.sv
// Directed plus randomized bench for wb_tlul_bridge against a transaction-level model.
module tb_wb_tlul_bridge;
    localparam int SRC_W  = 8;
    localparam int SRC_ID = 90;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]       wbs_sel_i;
    logic [31:0]      wbs_adr_i, wbs_dat_i;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic             tl_a_valid_o, tl_a_ready_i;
    logic [2:0]       tl_a_opcode_o;
    logic [1:0]       tl_a_size_o;
    logic [3:0]       tl_a_mask_o;
    logic [31:0]      tl_a_address_o, tl_a_data_o;
    logic [SRC_W-1:0] tl_a_source_o;
    logic             tl_d_valid_i, tl_d_ready_o;
    logic [2:0]       tl_d_opcode_i;
    logic [31:0]      tl_d_data_i;
    logic             tl_d_error_i;
    logic [SRC_W-1:0] tl_d_source_i;

    wb_tlul_bridge #(.SRC_ID(SRC_ID), .SRC_W(SRC_W), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .tl_a_valid_o(tl_a_valid_o), .tl_a_ready_i(tl_a_ready_i),
        .tl_a_opcode_o(tl_a_opcode_o), .tl_a_size_o(tl_a_size_o), .tl_a_mask_o(tl_a_mask_o),
        .tl_a_address_o(tl_a_address_o), .tl_a_data_o(tl_a_data_o), .tl_a_source_o(tl_a_source_o),
        .tl_d_valid_i(tl_d_valid_i), .tl_d_ready_o(tl_d_ready_o),
        .tl_d_opcode_i(tl_d_opcode_i), .tl_d_data_i(tl_d_data_i),
        .tl_d_error_i(tl_d_error_i), .tl_d_source_i(tl_d_source_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_op(input logic we, input logic [3:0] sel);
        if (!we) return 3'd4;
        return (sel == 4'hF) ? 3'd0 : 3'd1;
    endfunction

    // One Wishbone access: A ready withheld na cycles, D withheld nd cycles in D_WAIT.
    // tmo=1 means D is never answered and the response comes from the timeout.
    task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [31:0] rdata,
                       input int na, input int nd, input logic err,
                       input logic abort, input logic tmo);
        logic [31:0] exp_adr;
        exp_adr = adr & 32'hFFFF_FFFC;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        tl_a_ready_i = 1'b0; tl_d_valid_i = 1'b0;
        for (int t = 1; t <= na + nd + 3; t++) begin
            @(negedge wb_clk_i);
            if (t <= na + 1) begin
                chk("a_valid", 32'(tl_a_valid_o), 32'd1);
                chk("a_opcode", 32'(tl_a_opcode_o), 32'(exp_op(we, sel)));
                chk("a_mask", 32'(tl_a_mask_o), 32'(sel));
                chk("a_address", tl_a_address_o, exp_adr);
                chk("a_data", tl_a_data_o, dat);
                chk("a_size", 32'(tl_a_size_o), 32'd2);
                chk("a_source", 32'(tl_a_source_o), 32'(SRC_ID));
                chk("ack_early_a", 32'(wbs_ack_o), 32'd0);
                tl_a_ready_i = (t == na + 1);
            end else if (t <= na + 2 + nd) begin
                tl_a_ready_i = 1'b0;
                chk("a_valid_after_hs", 32'(tl_a_valid_o), 32'd0);
                chk("d_ready_wait", 32'(tl_d_ready_o), 32'd1);
                chk("ack_early_d", 32'(wbs_ack_o), 32'd0);
                if (abort && t == na + 2) begin
                    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                end
                tl_d_valid_i  = !tmo && (t == na + 2 + nd);
                tl_d_data_i   = rdata;
                tl_d_error_i  = err;
                tl_d_opcode_i = 3'($urandom_range(0, 7));
                tl_d_source_i = SRC_W'($urandom);
            end else begin
                tl_d_valid_i = 1'b0; tl_d_error_i = 1'b0;
                if (err || tmo) exp_dat = 32'hFFFF_FFFF;
                else if (!we)   exp_dat = rdata;
                chk("ack", 32'(wbs_ack_o), 32'(!abort));
                chk("rdata", wbs_dat_o, exp_dat);
                wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
            end
        end
        @(negedge wb_clk_i);
        chk("ack_single", 32'(wbs_ack_o), 32'd0);
        chk("idle_a_valid", 32'(tl_a_valid_o), 32'd0);
        chk("idle_d_ready", 32'(tl_d_ready_o), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'd0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
        tl_a_ready_i = 1'b0; tl_d_valid_i = 1'b0; tl_d_opcode_i = 3'd0;
        tl_d_data_i = 32'd0; tl_d_error_i = 1'b0; tl_d_source_i = '0;
        exp_dat = 32'd0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_a_valid", 32'(tl_a_valid_o), 32'd0);
        chk("rst_d_ready", 32'(tl_d_ready_o), 32'd1);
        chk("rst_mask", 32'(tl_a_mask_o), 32'd0);
        chk("rst_address", tl_a_address_o, 32'd0);
        chk("rst_data", tl_a_data_o, 32'd0);

        // directed: read, full write, partial write, backpressure, error, abort
        txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 32'hA5A5_1234, 0, 0, 1'b0, 1'b0, 1'b0);
        txn(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0, 1'b0);
        txn(1'b1, 4'h3, 32'h3000_0006, 32'h1122_3344, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
        txn(1'b0, 4'h5, 32'h3000_0020, 32'h0, 32'h0BAD_F00D, 5, 0, 1'b0, 1'b0, 1'b0);
        txn(1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'h7777_7777, 0, 2, 1'b1, 1'b0, 1'b0);
        txn(1'b0, 4'hF, 32'h3000_0028, 32'h0, 32'h2468_ACE0, 1, 2, 1'b0, 1'b1, 1'b0);

`ifdef WB_TLUL_TIMEOUT_EN
        // eight D_WAIT cycles with no response, then timeout ack
        txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'h0, 0, 7, 1'b0, 1'b0, 1'b1);
`else
        txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'hCAFE_0001, 0, 30, 1'b0, 1'b0, 1'b0);
`endif

        // stray/late D beat in IDLE is swallowed
        tl_d_valid_i = 1'b1; tl_d_data_i = 32'h5555_AAAA; tl_d_error_i = 1'b1;
        @(negedge wb_clk_i);
        tl_d_valid_i = 1'b0; tl_d_error_i = 1'b0;
        @(negedge wb_clk_i);
        chk("stray_ack", 32'(wbs_ack_o), 32'd0);
        chk("stray_dat", wbs_dat_o, exp_dat);
        chk("stray_a_valid", 32'(tl_a_valid_o), 32'd0);
        chk("stray_d_ready", 32'(tl_d_ready_o), 32'd1);

        for (int i = 0; i < 25; i++) begin
            txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'b0);
        end

        // reset while the A request is outstanding
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h1234_5678;
        tl_a_ready_i = 1'b0;
        @(negedge wb_clk_i);
        chk("pre_rst_a_valid", 32'(tl_a_valid_o), 32'd1);
        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0; tl_a_ready_i = 1'b1;
        exp_dat = 32'd0;
        chk("midrst_a_valid", 32'(tl_a_valid_o), 32'd0);
        chk("midrst_d_ready", 32'(tl_d_ready_o), 32'd1);
        chk("midrst_dat", wbs_dat_o, exp_dat);
        chk("midrst_address", tl_a_address_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            chk("midrst_no_ack", 32'(wbs_ack_o), 32'd0);
            chk("midrst_idle", 32'(tl_a_valid_o), 32'd0);
        end
        tl_a_ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_tlul_bridge.md
# wb_tlul_bridge

Single-outstanding bridge that converts the Caravel Wishbone slave port (driven by the management SoC) into TileLink-UL host requests on the Azadi SoC crossbar. Sits directly downstream of the user project wrapper's Wishbone pins and upstream of the crossbar's host port. Every Wishbone access becomes exactly one 32-bit TL-UL A/D exchange. The Wishbone ack is held back until the D response returns, or until a configurable timeout expires.

## Interface
- SRC_ID, 0: constant value driven on tl_a_source_o.
- SRC_W, 8: width of the TL source field.
- TIMEOUT_CYCLES, 1023: D-channel wait limit in cycles, 1..65535. Used only with the timeout feature.

- wb_clk_i  in  1  sole clock; all state is updated on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  registered read data
- tl_a_valid_o  out  1;  tl_a_ready_i  in  1
- tl_a_opcode_o  out  3;  tl_a_size_o  out  2;  tl_a_mask_o  out  4
- tl_a_address_o, tl_a_data_o  out  32 each;  tl_a_source_o  out  SRC_W
- tl_d_valid_i  in  1;  tl_d_ready_o  out  1
- tl_d_opcode_i  in  3;  tl_d_data_i  in  32;  tl_d_error_i  in  1;  tl_d_source_i  in  SRC_W

## Operation
- FSM states and transitions:
  - IDLE: when wbs_stb_i and wbs_cyc_i are both high, capture we, sel, adr and dat into request registers, then go to A_REQ.
  - A_REQ: drive tl_a_valid_o=1. When tl_a_ready_i=1, go to D_WAIT.
  - D_WAIT: drive tl_d_ready_o=1. When tl_d_valid_i=1, capture the response, then go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then go to IDLE.
- A channel encoding:
  - Read: opcode Get (4).
  - Write with sel=4'hF: PutFullData (0).
  - Write with any other sel: PutPartialData (1).
  - size is always 2. mask = captured sel, reads included. address = captured adr with bits [1:0] forced to 0. data = captured dat.
- A channel payload is stable for as long as tl_a_valid_o is high. tl_a_valid_o never deasserts before the handshake completes.
- Response capture:
  - tl_d_error_i=0 and read: wbs_dat_o <= tl_d_data_i.
  - tl_d_error_i=1: wbs_dat_o <= 32'hFFFF_FFFF.
  - Write without error: wbs_dat_o is unchanged.
  - tl_d_opcode_i and tl_d_source_i are ignored.
- tl_d_ready_o is also high in IDLE. Any stray D beat arriving in IDLE is accepted and discarded.
- If wbs_cyc_i is low on entry to ACK, the ack pulse is suppressed (aborted master). The TL exchange still completes.
- Outstanding limit is 1. A new request is never sampled outside IDLE.

## Timing
- Reset values: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, tl_a_valid_o=0, tl_d_ready_o=1 (IDLE), all request registers 0.
- Minimum latency (a_ready and d_valid both answering immediately):
  - stb sampled at edge 0.
  - tl_a_valid_o high in cycle 1; handshake at edge 1.
  - D accepted at edge 2.
  - wbs_ack_o high in cycle 3.
  - Total: 3 cycles from stb to ack.
- The cycle after ack is always IDLE. A request still presented there is treated as a new access, so the master must drop stb after ack.
- A wb_rst_i asserted in any state returns the FSM to IDLE at the next edge. Any in-flight A request is dropped and no ack is issued.

## Configuration
- WB_TLUL_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to D_WAIT and increments each cycle in D_WAIT.
  - When the counter reaches TIMEOUT_CYCLES without tl_d_valid_i, wbs_dat_o <= 32'hFFFF_FFFF and the FSM goes to ACK.
  - The late response later arrives in IDLE and is discarded.
  - A_REQ never times out.
- WB_TLUL_TIMEOUT_EN undefined: no counter exists, and D_WAIT waits indefinitely.

## Test plan
- Read: adr=0x3000_0004, sel=F, D returns data 0xA5A5_1234 one cycle after the A handshake -> opcode 4, mask F, address 0x3000_0004; ack in cycle 3; wbs_dat_o=0xA5A5_1234.
- Full write: we=1, sel=F, dat=0xDEAD_BEEF -> opcode 0, data 0xDEAD_BEEF; ack after D; wbs_dat_o unchanged.
- Partial write: sel=4'b0011, adr=0x3000_0006 -> opcode 1, mask 3, address 0x3000_0004.
- Backpressure: tl_a_ready_i low for 5 cycles -> tl_a_valid_o high and the A payload constant all 5 cycles; ack 3 cycles after ready rises.
- Error and abort: tl_d_error_i=1 on a read -> wbs_dat_o=0xFFFF_FFFF. Separately, cyc dropped during D_WAIT -> no ack pulse, FSM returns to IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=8): D response withheld -> ack 8 cycles after entering D_WAIT with data 0xFFFF_FFFF; a late D beat in IDLE is accepted and produces no ack.
